cp0_ctrl: RTL and testbench

Coprocessor-0 control block for the P7 pipelined MIPS core. It holds SR, Cause, EPC and PRId, and serves mfc0/mtc0 from the M stage. It arbitrates hardware interrupts against synchronous exceptions carried down the pipe. It drives the `Req` and `EPC` signals that the next-PC logic uses to redirect fetch to the handler at 0x0000_4180, or back to the victim address on eret.

---
 rtl/cp0_ctrl.sv | 89 ++++++++
 tb/tb_cp0_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 for the P7 pipeline: SR/Cause/EPC/PRId storage, mfc0/mtc0 service,
// and interrupt/exception arbitration driving the next-PC redirect request.
module cp0_ctrl #(
   parameter logic [31:0] PRID_VAL = 32'h4A45_5758
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPC,
   output logic [31:0] DOut
);

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exccode;
   logic [31:0] r_epc;

   logic        w_int_req;
   logic        w_exc_req;
   logic        w_mtc0;

   assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
   assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
   assign Req       = w_int_req | w_exc_req;
   assign w_mtc0    = WE & ~Req;
   assign EPC       = r_epc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_im      <= 6'd0;
         r_exl     <= 1'b0;
         r_ie      <= 1'b0;
         r_bd      <= 1'b0;
         r_ip      <= 6'd0;
         r_exccode <= 5'd0;
         r_epc     <= 32'd0;
      end else begin
         r_ip <= HWInt;
         if (Req) begin
            // Interrupt outranks a concurrent exception: code 0 reports it.
            r_exl     <= 1'b1;
            r_bd      <= BDIn;
            r_epc     <= BDIn ? (VPC - 32'd4) : VPC;
            r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
         end else begin
            if (w_mtc0 && A2 == REG_SR) begin
               r_im <= DIn[15:10];
               r_ie <= DIn[0];
            end
            if (w_mtc0 && A2 == REG_EPC)
               r_epc <= {DIn[31:2], 2'b00};
            // eret overrides an SR write on the EXL bit only.
            if (EXLClr)
               r_exl <= 1'b0;
            else if (w_mtc0 && A2 == REG_SR)
               r_exl <= DIn[1];
         end
      end
   end

   always_comb begin
      DOut = 32'd0;
      case (A1)
         REG_SR:    DOut = {16'd0, r_im, 8'd0, r_exl, r_ie};
         REG_CAUSE: DOut = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
         REG_EPC:   DOut = r_epc;
         REG_PRID:  DOut = PRID_VAL;
         default:   DOut = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: word-level reference model checked every cycle, plus
// directed scenarios with literal expected values.
module tb_cp0_ctrl;

   localparam logic [31:0] PRID = 32'h4A45_5758;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2, ExcCodeIn;
   logic [31:0] DIn, VPC;
   logic        WE, BDIn, EXLClr;
   logic [5:0]  HWInt;
   logic        Req;
   logic [31:0] EPC, DOut;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Model state kept as architectural 32-bit words.
   logic [31:0] m_sr = 32'd0, m_cause = 32'd0, m_epc = 32'd0;

   cp0_ctrl #(.PRID_VAL(PRID)) dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
      .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
      .EXLClr(EXLClr), .Req(Req), .EPC(EPC), .DOut(DOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic m_int();
      return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_req();
      return m_int() || (ExcCodeIn != 5'd0 && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_dout();
      case (A1)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      logic [31:0] s, c, e;
      s = m_sr; c = m_cause; e = m_epc;
      if (!reset) begin
         s = 0; c = 0; e = 0;
      end else if (m_req()) begin
         s = s | 32'h2;
         e = VPC - (BDIn ? 32'd4 : 32'd0);
         c = (BDIn ? 32'h8000_0000 : 32'd0) | (32'(HWInt) << 10)
             | (m_int() ? 32'd0 : (32'(ExcCodeIn) << 2));
      end else begin
         if (WE && A2 == 5'd12) s = DIn & 32'h0000_FC03;
         if (WE && A2 == 5'd14) e = DIn & 32'hFFFF_FFFC;
         if (EXLClr) s = s & ~32'h2;
         c = (c & ~32'h0000_FC00) | (32'(HWInt) << 10);
      end
      m_sr <= s; m_cause <= c; m_epc <= e;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_Req",  {31'd0, Req}, {31'd0, m_req()});
         chk("model_EPC",  EPC,  m_epc);
         chk("model_DOut", DOut, m_dout());
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [4:0] a, input string nm, input logic [31:0] exp);
      A1 = a; #1;
      chk(nm, DOut, exp);
   endtask

   initial begin
      reset = 1'b0; A1 = 5'd12; A2 = 0; DIn = 0; WE = 0; VPC = 0; BDIn = 0;
      ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
      tick(); chk_en = 1'b1;
      tick(); reset = 1'b1;

      // Reset state
      @(negedge clk); #1;
      chk("rst_Req", {31'd0, Req}, 32'd0);
      rd(5'd12, "rst_SR", 32'd0);
      rd(5'd13, "rst_Cause", 32'd0);
      rd(5'd14, "rst_EPC", 32'd0);
      rd(5'd15, "rst_PRId", 32'h4A45_5758);
      rd(5'd7,  "rst_other", 32'd0);
      tick();

      // Interrupt
      WE = 1; A2 = 5'd12; DIn = 32'h0000_0401; tick();
      WE = 0; HWInt = 6'b000001; VPC = 32'h0000_3010; BDIn = 0;
      @(negedge clk); #1; chk("int_Req", {31'd0, Req}, 32'd1);
      tick();
      @(negedge clk); #1;
      chk("int_Req_after", {31'd0, Req}, 32'd0);
      chk("int_EPC", EPC, 32'h0000_3010);
      rd(5'd13, "int_Cause", 32'h0000_0400);
      rd(5'd12, "int_SR", 32'h0000_0403);
      tick();

      // mtc0 to Cause ignored; clear SR, then delay-slot exception
      HWInt = 0; WE = 1; A2 = 5'd13; DIn = 32'hFFFF_FFFF; tick();
      A2 = 5'd12; DIn = 32'd0; tick();
      WE = 0; ExcCodeIn = 5'd12; VPC = 32'h0000_3024; BDIn = 1;
      @(negedge clk); #1; chk("ds_Req", {31'd0, Req}, 32'd1);
      tick();
      ExcCodeIn = 0; BDIn = 0;
      @(negedge clk); #1;
      chk("ds_EPC", EPC, 32'h0000_3020);
      rd(5'd13, "ds_Cause", 32'h8000_0030);
      tick();

      // EXL masks exceptions
      ExcCodeIn = 5'd4; VPC = 32'h0000_5000;
      @(negedge clk); #1; chk("exl_Req", {31'd0, Req}, 32'd0);
      tick(); ExcCodeIn = 0;
      @(negedge clk); #1; chk("exl_EPC", EPC, 32'h0000_3020);
      tick();

      // IE=0 masks interrupts
      WE = 1; A2 = 5'd12; DIn = 32'h0000_FC00; tick();
      WE = 0; HWInt = 6'h3F;
      @(negedge clk); #1; chk("ie_Req", {31'd0, Req}, 32'd0);
      tick(); HWInt = 0;

      // Req discards concurrent mtc0 EPC
      ExcCodeIn = 5'd4; VPC = 32'h0000_6000; BDIn = 0;
      WE = 1; A2 = 5'd14; DIn = 32'h1234_5677;
      @(negedge clk); #1; chk("cf_Req", {31'd0, Req}, 32'd1);
      tick(); ExcCodeIn = 0; WE = 0;
      @(negedge clk); #1; chk("cf_EPC_req", EPC, 32'h0000_6000);
      tick();
      WE = 1; A2 = 5'd14; DIn = 32'h1234_5677; tick(); WE = 0;
      @(negedge clk); #1; chk("cf_EPC_mtc0", EPC, 32'h1234_5674);
      tick();

      // EXLClr wins over SR write on EXL
      HWInt = 6'b000001; WE = 1; A2 = 5'd12; DIn = 32'h0000_FC03; EXLClr = 1;
      tick(); WE = 0; EXLClr = 0; VPC = 32'h0000_7000;
      @(negedge clk); #1;
      rd(5'd12, "eret_SR", 32'h0000_FC01);
      chk("eret_Req", {31'd0, Req}, 32'd1);
      tick(); HWInt = 0;
      @(negedge clk); #1; chk("eret_EPC", EPC, 32'h0000_7000);
      tick();

      // Reset mid-handler
      reset = 0; tick(); reset = 1;
      @(negedge clk); #1;
      chk("rst2_EPC", EPC, 32'd0);
      rd(5'd12, "rst2_SR", 32'd0);
      tick();

      // EPC wrap on delay-slot at address 0
      ExcCodeIn = 5'd8; VPC = 32'd0; BDIn = 1; tick();
      ExcCodeIn = 0; BDIn = 0;
      @(negedge clk); #1;
      chk("wrap_EPC", EPC, 32'hFFFF_FFFC);
      rd(5'd13, "wrap_Cause", 32'h8000_0020);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
